// File: rtl/addn_tree_acc.sv
// Pipelined NUM_IN-input adder tree with an optional running accumulator and a sticky overflow flag.
// Latency: LOG2N+2 cycles from the sampling edge to OUT_VALID/SUM_OUT; one result per cycle.
// No backpressure: one input set is accepted every cycle, and every valid set produces one output pulse.
module addn_tree_acc #(
  parameter int WIDTH     = 46,
  parameter int NUM_IN    = 4,
  parameter int LOG2N     = 2,
  parameter int ACC_GUARD = 0,
  parameter int SIGNED    = 0,
  localparam int OUT_W    = WIDTH + LOG2N + ACC_GUARD
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  input  logic [NUM_IN*WIDTH-1:0] DIN_BUS,
  input  logic                    ACC_EN,
  input  logic                    ACC_CLR,
  output logic                    OUT_VALID,
  output logic [OUT_W-1:0]        SUM_OUT,
  output logic                    OVF
);

  // All tree levels live in one flat array: level s starts at lvl_off(s)
  // and holds NUM_IN >> s partial sums; the last element is the tree sum.
  localparam int NODES = 2 * NUM_IN - 1;

  function automatic int lvl_off(input int s);
    return 2 * NUM_IN - 2 * (NUM_IN >> s);
  endfunction

  function automatic logic [OUT_W-1:0] ext(input logic [WIDTH-1:0] x);
    if (SIGNED != 0) return {{(OUT_W - WIDTH){x[WIDTH-1]}}, x};
    return {{(OUT_W - WIDTH){1'b0}}, x};
  endfunction

  if (NUM_IN < 2 || NUM_IN > 16 || (1 << LOG2N) != NUM_IN) begin : g_bad_param
    $error("addn_tree_acc: NUM_IN must be a power of two in 2..16 and LOG2N = log2(NUM_IN)");
  end

  logic [OUT_W-1:0] node [NODES];
  logic [LOG2N:0]   vld_p;
  logic [LOG2N:0]   en_p;
  logic [LOG2N:0]   clr_p;
  logic [OUT_W-1:0] tree_sum;

  // Accumulator stage state, retimed once more into the output registers.
  logic [OUT_W-1:0] acc_q;
  logic             ovf_q;
  logic             acc_vld;
  logic [OUT_W:0]   acc_full;
  logic             acc_ovf;

  // Stage 0: capture and extend every operand to the output width.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (RST) node[k] <= '0;
      else     node[k] <= ext(DIN_BUS[k*WIDTH +: WIDTH]);
    end
  end

  // Control tags ride alongside the data so each set keeps its own mode bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p <= '0;
      en_p  <= '0;
      clr_p <= '0;
    end else begin
      vld_p[0] <= IN_VALID;
      en_p[0]  <= ACC_EN;
      clr_p[0] <= ACC_CLR;
      for (int s = 1; s <= LOG2N; s++) begin
        vld_p[s] <= vld_p[s-1];
        en_p[s]  <= en_p[s-1];
        clr_p[s] <= clr_p[s-1];
      end
    end
  end

  for (genvar s = 1; s <= LOG2N; s++) begin : g_lvl
    localparam int OFF_IN  = lvl_off(s - 1);
    localparam int OFF_OUT = lvl_off(s);
    localparam int N       = NUM_IN >> s;

    // Stage s: add adjacent pairs from the previous level; width headroom means no overflow.
    always_ff @(posedge CLK) begin
      for (int k = 0; k < N; k++) begin
        if (RST) node[OFF_OUT + k] <= '0;
        else     node[OFF_OUT + k] <= node[OFF_IN + 2*k] + node[OFF_IN + 2*k + 1];
      end
    end
  end

  assign tree_sum = node[NODES-1];

  // Accumulate adder with carry and signed-overflow detection.
  always_comb begin
    acc_full = {1'b0, acc_q} + {1'b0, tree_sum};
    if (SIGNED != 0)
      acc_ovf = (acc_q[OUT_W-1] == tree_sum[OUT_W-1]) &&
                (acc_full[OUT_W-1] != acc_q[OUT_W-1]);
    else
      acc_ovf = acc_full[OUT_W];
  end

  // Accumulator: single-cycle feedback so back-to-back accumulates chain at full rate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      acc_vld <= 1'b0;
    end else begin
      acc_vld <= vld_p[LOG2N];
      if (vld_p[LOG2N]) begin
        if (!en_p[LOG2N]) begin
          acc_q <= tree_sum;
        end else if (clr_p[LOG2N]) begin
          acc_q <= tree_sum;
          ovf_q <= 1'b0;
        end else begin
          acc_q <= acc_full[OUT_W-1:0];
          ovf_q <= ovf_q | acc_ovf;
        end
      end
    end
  end

  // Output register: acc_q/ovf_q only move on valid tags, so the outputs hold between results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      SUM_OUT   <= '0;
      OVF       <= 1'b0;
    end else begin
      OUT_VALID <= acc_vld;
      SUM_OUT   <= acc_q;
      OVF       <= ovf_q;
    end
  end

endmodule

// File: tb/tb_addn_tree_acc.sv
// Bench for addn_tree_acc: unsigned and signed instances share stimulus.
// Expected outputs come from an arithmetic reference model fed through a delay line.
// Inputs are driven and outputs sampled on the falling edge.
module tb_addn_tree_acc;
  localparam int W = 46;
  localparam longint M48 = 64'h0001_0000_0000_0000;
  localparam longint H47 = 64'h0000_8000_0000_0000;
  localparam longint H46 = 64'h0000_4000_0000_0000;

  typedef struct {
    bit r;
    bit v;
    bit en;
    bit clr;
    logic [3:0][W-1:0] o;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic acc_en = 1'b0;
  logic acc_clr = 1'b0;
  logic [4*W-1:0] din = '0;

  logic ov_u, of_u, ov_s, of_s;
  logic [W+1:0] so_u, so_s;

  int total = 0;
  int bad = 0;

  // Reference model state (as integers).
  longint m_u = 0;
  bit     m_ou = 1'b0;
  longint m_s = 0;
  bit     m_os = 1'b0;

  // Expected-output delay line; index 5 is due at the current sample point.
  bit        d_v  [6];
  bit [47:0] d_su [6];
  bit        d_ou [6];
  bit [47:0] d_ss [6];
  bit        d_os [6];

  always #5 clk = ~clk;

  addn_tree_acc #(.SIGNED(0)) u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .DIN_BUS(din),
    .ACC_EN(acc_en), .ACC_CLR(acc_clr),
    .OUT_VALID(ov_u), .SUM_OUT(so_u), .OVF(of_u)
  );

  addn_tree_acc #(.SIGNED(1)) s_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .DIN_BUS(din),
    .ACC_EN(acc_en), .ACC_CLR(acc_clr),
    .OUT_VALID(ov_s), .SUM_OUT(so_s), .OVF(of_s)
  );

  function automatic stim_t mk(input logic [3:0] ctl,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d);
    stim_t s;
    s.r = ctl[3]; s.v = ctl[2]; s.en = ctl[1]; s.clr = ctl[0];
    s.o[0] = a; s.o[1] = b; s.o[2] = c; s.o[3] = d;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(4'b0000, '0, '0, '0, '0);
  endfunction

  task automatic model_step(input bit en, input bit clr, input logic [3:0][W-1:0] o);
    longint tu, ts, x, f;
    tu = 0;
    ts = 0;
    for (int k = 0; k < 4; k++) begin
      x = longint'({18'd0, o[k]});
      tu += x;
      ts += o[k][W-1] ? x - H46 : x;
    end
    if (!en || clr) begin
      m_u = tu;
      m_s = ts;
      if (en) begin
        m_ou = 1'b0;
        m_os = 1'b0;
      end
    end else begin
      f = m_u + tu;
      if (f >= M48) begin
        m_ou = 1'b1;
        f -= M48;
      end
      m_u = f;
      f = m_s + ts;
      if (f >= H47) begin
        m_os = 1'b1;
        f -= M48;
      end else if (f < -H47) begin
        m_os = 1'b1;
        f += M48;
      end
      m_s = f;
    end
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    for (int i = 5; i > 0; i--) begin
      d_v[i] = d_v[i-1]; d_su[i] = d_su[i-1]; d_ou[i] = d_ou[i-1];
      d_ss[i] = d_ss[i-1]; d_os[i] = d_os[i-1];
    end
    rst = s.r; in_valid = s.v; acc_en = s.en; acc_clr = s.clr; din = s.o;
    if (s.r) begin
      m_u = 0; m_ou = 1'b0; m_s = 0; m_os = 1'b0;
      for (int i = 1; i < 5; i++) begin
        d_v[i] = 1'b0; d_su[i] = '0; d_ou[i] = 1'b0; d_ss[i] = '0; d_os[i] = 1'b0;
      end
    end else if (s.v) begin
      model_step(s.en, s.clr, s.o);
    end
    d_v[0] = s.v & ~s.r;
    d_su[0] = m_u[47:0]; d_ou[0] = m_ou;
    d_ss[0] = m_s[47:0]; d_os[0] = m_os;
  endtask

  task automatic test_reset();
    stim_t q[$];
    q.push_back(mk(4'b1000, '0, '0, '0, '0));
    q.push_back(mk(4'b1000, '0, '0, '0, '0));
    repeat (4) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      if (i > 0) begin
        total++;
        if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
          bad++;
          $display("FAIL reset_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
        end
        total++;
        if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
          bad++;
          $display("FAIL reset_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
        end
      end
    end
  endtask

  task automatic test_pass();
    stim_t q[$];
    q.push_back(mk(4'b0100, 46'd512, 46'd512, 46'd514, 46'd512));
    repeat (7) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL pass_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL pass_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_stream();
    stim_t q[$];
    logic [W-1:0] mx;
    mx = '1;
    q.push_back(mk(4'b0100, mx, mx, mx, mx));
    q.push_back(mk(4'b0100, 46'd2020, 46'd2020, 46'd2000, 46'd2020));
    q.push_back(mk(4'b0100, 46'd10, 46'd10, 46'd14, 46'd10));
    repeat (6) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL stream_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL stream_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_accumulate();
    stim_t q[$];
    q.push_back(mk(4'b0111, 46'd1, 46'd1, 46'd1, 46'd1));
    repeat (3) q.push_back(mk(4'b0110, 46'd1, 46'd1, 46'd1, 46'd1));
    repeat (6) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL acc_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL acc_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t q[$];
    logic [W-1:0] mx;
    mx = '1;
    q.push_back(mk(4'b0111, mx, mx, mx, mx));
    q.push_back(mk(4'b0110, mx, mx, mx, mx));
    q.push_back(idle());
    q.push_back(mk(4'b0100, 46'd7, 46'd8, 46'd9, 46'd10));
    q.push_back(mk(4'b0101, 46'd1, 46'd2, 46'd3, 46'd4));
    q.push_back(mk(4'b0111, 46'd5, 46'd5, 46'd5, 46'd5));
    repeat (6) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL ovf_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL ovf_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_signed();
    stim_t q[$];
    logic [W-1:0] m1, m2, pmax, nmin;
    m1 = '1;
    m2 = m1 - 46'd1;
    pmax = {1'b0, {(W-1){1'b1}}};
    nmin = {1'b1, {(W-1){1'b0}}};
    q.push_back(mk(4'b0100, m1, m1, m1, m1));
    q.push_back(mk(4'b0100, 46'd1, m1, 46'd5, m2));
    q.push_back(mk(4'b0111, pmax, pmax, pmax, pmax));
    q.push_back(mk(4'b0110, pmax, pmax, pmax, pmax));
    q.push_back(mk(4'b0111, nmin, nmin, nmin, nmin));
    q.push_back(mk(4'b0110, nmin, nmin, nmin, nmin));
    repeat (6) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL signed_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL signed_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t q[$];
    logic [W-1:0] mx;
    mx = '1;
    q.push_back(mk(4'b0111, mx, mx, mx, mx));
    q.push_back(mk(4'b0110, mx, mx, mx, mx));
    repeat (5) q.push_back(idle());
    q.push_back(mk(4'b0100, 46'd100, 46'd200, 46'd300, 46'd400));
    q.push_back(mk(4'b0110, 46'd1, 46'd1, 46'd1, 46'd1));
    q.push_back(mk(4'b0111, 46'd9, 46'd9, 46'd9, 46'd9));
    q.push_back(mk(4'b1100, 46'd3, 46'd3, 46'd3, 46'd3));
    q.push_back(mk(4'b0100, 46'd11, 46'd22, 46'd33, 46'd44));
    repeat (7) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL rstmid_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL rstmid_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  task automatic test_random();
    stim_t q[$];
    stim_t s;
    logic [63:0] rr;
    int mode;
    for (int n = 0; n < 400; n++) begin
      s.r   = ($urandom_range(0, 99) == 0);
      s.v   = ($urandom_range(0, 3) != 0);
      s.en  = ($urandom_range(0, 2) != 0);
      s.clr = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 4; k++) begin
        rr = {$urandom(), $urandom()};
        mode = $urandom_range(0, 4);
        case (mode)
          0: s.o[k] = '1;
          1: s.o[k] = {1'b0, {(W-1){1'b1}}};
          2: s.o[k] = {1'b1, {(W-1){1'b0}}};
          3: s.o[k] = {{(W-8){1'b0}}, rr[7:0]};
          default: s.o[k] = rr[W-1:0];
        endcase
      end
      q.push_back(s);
    end
    repeat (6) q.push_back(idle());
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      total++;
      if ({ov_u, of_u, so_u} !== {d_v[5], d_ou[5], d_su[5]}) begin
        bad++;
        $display("FAIL rand_u i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_u, of_u, so_u, d_v[5], d_ou[5], d_su[5]);
      end
      total++;
      if ({ov_s, of_s, so_s} !== {d_v[5], d_os[5], d_ss[5]}) begin
        bad++;
        $display("FAIL rand_s i=%0d got v=%b ovf=%b sum=%h exp v=%b ovf=%b sum=%h", i, ov_s, of_s, so_s, d_v[5], d_os[5], d_ss[5]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_stream();
    test_accumulate();
    test_overflow();
    test_signed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addn_tree_acc.md
# addn_tree_acc

Parametrised, fully pipelined N-input adder tree with an optional running accumulator and overflow flag. It succeeds the fixed 4×46-bit adder in the DSP48E application set. It sits in the DSP datapath wherever several equal-width channel products or partial sums must be reduced to one result per clock. Each input set carries a valid tag through the pipeline.

## Interface
- WIDTH, 46: width of each input operand.
- NUM_IN, 4: number of operands. Must be a power of two, 2..16.
- LOG2N, 2: log2(NUM_IN). Elaboration fails if LOG2N ≠ log2(NUM_IN).
- ACC_GUARD, 0: extra accumulator guard bits. OUT_W = WIDTH + LOG2N + ACC_GUARD.
- SIGNED, 0: 0 = unsigned operands and zero extension; 1 = two's complement and sign extension.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  DIN_BUS, ACC_EN and ACC_CLR are sampled this cycle.
- DIN_BUS  in  NUM_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- ACC_EN  in  1  1 = add this tree sum to the accumulator; 0 = pass the tree sum through.
- ACC_CLR  in  1  with ACC_EN = 1: load the tree sum into the accumulator (discarding the old value) and clear OVF.
- OUT_VALID  out  1  one-cycle pulse per accepted input set.
- SUM_OUT  out  OUT_W  result.
- OVF  out  1  sticky accumulator overflow flag.

## Operation
**Stage 0 (input register)**
- Every cycle, register DIN_BUS, IN_VALID, ACC_EN and ACC_CLR.
- Extend each operand to OUT_W bits: sign extension if SIGNED = 1, zero extension otherwise.

**Stages 1..LOG2N (adder tree)**
- Each stage adds adjacent pairs from the previous stage and registers the results.
- Stage s holds NUM_IN/2^s partial sums.
- Control tags (valid, ACC_EN, ACC_CLR) shift in lockstep with the data.
- Arithmetic is modulo 2^OUT_W. The tree itself cannot overflow because OUT_W ≥ WIDTH + LOG2N.

**Stage LOG2N+1 (output/accumulator)**
Action is taken only when the tag valid = 1; T is the tree sum.
- ACC_EN = 0: SUM_OUT ← T. OVF is unchanged.
- ACC_EN = 1, ACC_CLR = 1: SUM_OUT ← T and OVF ← 0.
- ACC_EN = 1, ACC_CLR = 0: SUM_OUT ← SUM_OUT + T, wrapping modulo 2^OUT_W.
  - OVF ← 1 on unsigned carry-out when SIGNED = 0.
  - OVF ← 1 on signed overflow (operand signs equal, result sign differs) when SIGNED = 1.
  - Once set, OVF stays 1 until cleared.
- ACC_CLR with ACC_EN = 0 is ignored.

**When the tag valid = 0**
- SUM_OUT and OVF hold their values.
- OUT_VALID = 0.

There is no backpressure: the block accepts one input set every cycle.

## Timing
- Latency: IN_VALID at rising edge n → OUT_VALID = 1 and SUM_OUT valid after edge n + LOG2N + 2. With default parameters this is 4 cycles.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back OUT_VALID pulses in the same order.
- Accumulate chaining: consecutive ACC_EN inputs accumulate correctly at full rate, since the accumulator has a single-cycle feedback path.
- Reset:
  - All pipeline data and tags, SUM_OUT and OVF go to 0; OUT_VALID goes to 0.
  - Reset applies on the first edge where RST = 1.
  - Any input sets in flight when RST asserts are discarded and never produce OUT_VALID.
  - The first input sampled on the edge after RST deasserts is processed normally.
- Simultaneous events: input acceptance at stage 0 and accumulator update at the last stage are independent and may occur on the same edge.

## Test plan
1. **Pass-through, default parameters.** IN_VALID with operands 512, 512, 514, 512 and ACC_EN = 0 → OUT_VALID exactly 4 cycles later, SUM_OUT = 48'h000000000802 (2050). SUM_OUT holds afterwards.
2. **Maximum operands and streaming.** Four operands of 2^46−1 → SUM_OUT = 48'hFFFFFFFFFFFC. Stream 2020, 2020, 2000, 2020 then 10, 10, 14, 10 on consecutive cycles → consecutive results 8060 and 44 with no bubble.
3. **Accumulate.** Operands all 1:
   - First set with ACC_EN = 1, ACC_CLR = 1 → 4.
   - Next three sets with ACC_EN = 1, ACC_CLR = 0 → 8, 12, 16. OVF stays 0.
4. **Overflow.**
   - ACC_CLR load of all-max operands → 2^48−4, OVF = 0.
   - Accumulate the same set → SUM_OUT = 48'hFFFFFFFFFFF8 and OVF = 1.
   - A further ACC_EN = 0 pass leaves OVF = 1.
   - A subsequent ACC_CLR clears OVF to 0.
5. **Signed mode.** With SIGNED = 1, operands all 46'h3FFFFFFFFFFF (−1) → SUM_OUT = 48'hFFFFFFFFFFFC (−4). Operands 1, −1, 5, −2 → 3.
6. **Reset mid-stream.** Issue valid inputs on 3 consecutive cycles, then RST high for 1 cycle on the 4th → no OUT_VALID for the discarded sets, and SUM_OUT = 0, OVF = 0. A new input after reset → correct result after 4 cycles.
